// File: rtl/paddle_555_sampler_if.sv
// Signal bundle between the paddle sampler, the 555 timer circuit and the paddle renderer.
// o_State is a debug view of the sampler FSM (0 IDLE, 1 TRIGGER, 2 WAIT_HIGH, 3 MEASURE, 4 DONE).
`timescale 1ns/1ps
interface paddle_555_sampler_if #(
   parameter int POS_WIDTH = 10
);
   logic                 i_VSync;
   logic                 i_555_Output;
   logic                 o_555_Trigger;
   logic [POS_WIDTH-1:0] o_Position;
   logic                 o_Valid;
   logic                 o_Timeout;
   logic [2:0]           o_State;

   // o_Valid is a one-cycle strobe with no ready/back-pressure: the consumer must take
   // o_Position in that cycle; o_Position stays stable between strobes.
   modport master (
      input  i_VSync, i_555_Output,
      output o_555_Trigger, o_Position, o_Valid, o_Timeout, o_State
   );

   modport slave (
      output i_VSync, i_555_Output,
      input  o_555_Trigger, o_Position, o_Valid, o_Timeout, o_State
   );
endinterface

// File: rtl/paddle_555_sampler.sv
// Once per frame: pulse the 555 trigger, time the 555 output pulse, scale and clamp it into a paddle Y.
// Optional build macro PADDLE_SMOOTH_EN averages each new position with the previous one.
`timescale 1ns/1ps
module paddle_555_sampler #(
   parameter int TRIG_CYCLES = 25,
   parameter int CNT_WIDTH   = 18,
   parameter int MAX_COUNT   = 250000,
   parameter int SHIFT       = 9,
   parameter int POS_WIDTH   = 10,
   parameter int POS_MAX     = 440
) (
   input  logic                  i_Clk,
   input  logic                  i_Rst_L,
   paddle_555_sampler_if.master  bus
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      TRIGGER   = 3'd1,
      WAIT_HIGH = 3'd2,
      MEASURE   = 3'd3,
      DONE      = 3'd4
   } state_t;

   localparam logic [CNT_WIDTH-1:0] TRIG_LAST = CNT_WIDTH'(TRIG_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] MAX_LAST  = CNT_WIDTH'(MAX_COUNT - 1);
   localparam logic [CNT_WIDTH-1:0] MAX_C     = CNT_WIDTH'(MAX_COUNT);
   localparam logic [CNT_WIDTH-1:0] POS_MAX_C = CNT_WIDTH'(POS_MAX);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

   state_t               state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 sync1_q, s555_q;
   logic                 vsync_prev_q;
   logic                 trig_q, trig_d;
   logic                 valid_q, valid_d;
   logic                 timeout_q, timeout_d;
   logic [POS_WIDTH-1:0] pos_q, pos_d;

   logic                 frame_start;
   logic [CNT_WIDTH-1:0] shifted;
   logic [POS_WIDTH-1:0] clamped;
   logic [POS_WIDTH-1:0] pos_new;

   // i_555_Output is asynchronous; only the second flop's output is ever used.
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         sync1_q      <= 1'b0;
         s555_q       <= 1'b0;
         vsync_prev_q <= 1'b1;
      end else begin
         sync1_q      <= bus.i_555_Output;
         s555_q       <= sync1_q;
         vsync_prev_q <= bus.i_VSync;
      end
   end

   assign frame_start = vsync_prev_q & ~bus.i_VSync;

   assign shifted = cnt_q >> SHIFT;
   assign clamped = (shifted > POS_MAX_C) ? POS_WIDTH'(POS_MAX) : POS_WIDTH'(shifted);

`ifdef PADDLE_SMOOTH_EN
   logic [POS_WIDTH:0] pos_sum;
   assign pos_sum = {1'b0, pos_q} + {1'b0, clamped};
   assign pos_new = POS_WIDTH'(pos_sum >> 1);
`else
   assign pos_new = clamped;
`endif

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         trig_q    <= 1'b1;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
         pos_q     <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         trig_q    <= trig_d;
         valid_q   <= valid_d;
         timeout_q <= timeout_d;
         pos_q     <= pos_d;
      end
   end

   // Outputs are registered from next-state values, so o_Valid is high exactly in DONE
   // and the trigger is low exactly while in TRIGGER.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      trig_d    = 1'b1;
      valid_d   = 1'b0;
      timeout_d = timeout_q;
      pos_d     = pos_q;
      case (state_q)
         IDLE: begin
            if (frame_start) begin
               state_d = TRIGGER;
               cnt_d   = '0;
               trig_d  = 1'b0;
            end
         end
         TRIGGER: begin
            if (cnt_q == TRIG_LAST) begin
               state_d = WAIT_HIGH;
               cnt_d   = '0;
            end else begin
               cnt_d  = cnt_q + CNT_ONE;
               trig_d = 1'b0;
            end
         end
         WAIT_HIGH: begin
            if (s555_q) begin
               // The high sample that ends the wait is the pulse's first cycle.
               state_d = MEASURE;
               cnt_d   = CNT_ONE;
            end else if (cnt_q == MAX_LAST) begin
               state_d   = IDLE;
               cnt_d     = MAX_C;
               timeout_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         MEASURE: begin
            if (!s555_q) begin
               state_d   = DONE;
               valid_d   = 1'b1;
               timeout_d = 1'b0;
               pos_d     = pos_new;
            end else if (cnt_q == MAX_LAST) begin
               state_d   = IDLE;
               cnt_d     = MAX_C;
               timeout_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.o_555_Trigger = trig_q;
   assign bus.o_Position    = pos_q;
   assign bus.o_Valid       = valid_q;
   assign bus.o_Timeout     = timeout_q;
   assign bus.o_State       = state_q;

endmodule

// File: tb/tb_paddle_555_sampler.sv
// Bench for paddle_555_sampler: directed table of pulse widths, hand-written corner sequences,
// then random pulse widths checked against a frame-level model of the sampler.
`timescale 1ns/1ps
module tb_paddle_555_sampler;

   localparam int TRIG_CYCLES = 25;
   localparam int CNT_WIDTH   = 12;
   localparam int MAX_COUNT   = 4000;
   localparam int SHIFT       = 3;
   localparam int POS_WIDTH   = 10;
   localparam int POS_MAX     = 440;
   localparam int ST_IDLE     = 0;
   localparam int ST_DONE     = 4;
`ifdef PADDLE_SMOOTH_EN
   localparam bit SMOOTH = 1'b1;
`else
   localparam bit SMOOTH = 1'b0;
`endif

   logic clk;
   logic rst_n;

   paddle_555_sampler_if #(.POS_WIDTH(POS_WIDTH)) bus ();

   paddle_555_sampler #(
      .TRIG_CYCLES (TRIG_CYCLES),
      .CNT_WIDTH   (CNT_WIDTH),
      .MAX_COUNT   (MAX_COUNT),
      .SHIFT       (SHIFT),
      .POS_WIDTH   (POS_WIDTH),
      .POS_MAX     (POS_MAX)
   ) dut (
      .i_Clk   (clk),
      .i_Rst_L (rst_n),
      .bus     (bus.master)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #20 clk = ~clk;

   // ---------------- scoreboard state ----------------
   int n_checks = 0;
   int n_errors = 0;
   int valid_total = 0;
   int last_valid_pos = 0;
   int valid_in_trig = 0;
   logic [POS_WIDTH-1:0] exp_q[$];
   int exp_pos = 0;
   bit exp_to = 1'b0;
   bit exp_valid = 1'b0;

   always @(negedge clk) begin
      if (bus.o_Valid) begin
         valid_total    = valid_total + 1;
         last_valid_pos = int'(bus.o_Position);
      end
   end

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Frame-level model: a pulse of n cycles either times out or yields min(n>>SHIFT, POS_MAX).
   function automatic int model_new(input int n);
      int v;
      v = n >> SHIFT;
      return (v > POS_MAX) ? POS_MAX : v;
   endfunction

   function automatic bit model_timeout(input int n);
      return (n == 0) || (n >= MAX_COUNT);
   endfunction

   task automatic model_update(input bit to, input int new_val);
      if (to) begin
         exp_to    = 1'b1;
         exp_valid = 1'b0;
      end else begin
         exp_to    = 1'b0;
         exp_valid = 1'b1;
         exp_pos   = SMOOTH ? ((exp_pos + new_val) >> 1) : new_val;
         exp_q.push_back(POS_WIDTH'(exp_pos));
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic start_frame(output int lows);
      @(negedge clk);
      bus.i_VSync = 1'b0;
      @(negedge clk);
      bus.i_VSync = 1'b1;
      lows = 0;
      for (int i = 0; i < 200; i++) begin
         if (bus.o_555_Trigger == 1'b0) begin
            lows++;
            if (bus.o_Valid) valid_in_trig++;
         end else if (lows > 0) begin
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic drive_pulse(input int n, input bit extra);
      if (n > 0) begin
         bus.i_555_Output = 1'b1;
         for (int i = 0; i < n; i++) begin
            bus.i_VSync = (extra && (i % 50 == 10)) ? 1'b0 : 1'b1;
            @(negedge clk);
         end
         bus.i_VSync      = 1'b1;
         bus.i_555_Output = 1'b0;
      end
   endtask

   task automatic wait_idle(input string tag);
      bit ok;
      ok = 1'b0;
      repeat (6) @(negedge clk);
      for (int i = 0; i < MAX_COUNT + 100; i++) begin
         if (int'(bus.o_State) == ST_IDLE) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check($sformatf("%s idle_reached", tag), int'(ok), 1);
   endtask

   task automatic check_result(input string tag, input int v0);
      logic [POS_WIDTH-1:0] e;
      check($sformatf("%s valid_count", tag), valid_total - v0, int'(exp_valid));
      check($sformatf("%s position", tag), int'(bus.o_Position), exp_pos);
      check($sformatf("%s timeout", tag), int'(bus.o_Timeout), int'(exp_to));
      if (exp_valid) begin
         e = exp_q.pop_front();
         check($sformatf("%s strobed_pos", tag), last_valid_pos, int'(e));
      end
   endtask

   task automatic run_frame(input int n, input bit extra, input bit to, input int new_val,
                            input string tag);
      int lows;
      int v0;
      v0 = valid_total;
      start_frame(lows);
      check($sformatf("%s trig_len", tag), lows, TRIG_CYCLES);
      drive_pulse(n, extra);
      wait_idle(tag);
      model_update(to, new_val);
      check_result(tag, v0);
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      int pulse;
      bit extra_vsync;
      int exp_new;
      bit exp_timeout;
   } vec_t;

   vec_t vecs[13];

   initial begin
      int lows;
      int v0;
      int n;
      bit found;

      vecs[0]  = '{1600, 1'b0, 200, 1'b0};
      vecs[1]  = '{5000, 1'b0,   0, 1'b1};
      vecs[2]  = '{800,  1'b0, 100, 1'b0};
      vecs[3]  = '{3744, 1'b0, 440, 1'b0};
      vecs[4]  = '{1200, 1'b1, 150, 1'b0};
      vecs[5]  = '{0,    1'b0,   0, 1'b1};
      vecs[6]  = '{3520, 1'b0, 440, 1'b0};
      vecs[7]  = '{3519, 1'b0, 439, 1'b0};
      vecs[8]  = '{3999, 1'b0, 440, 1'b0};
      vecs[9]  = '{4000, 1'b0,   0, 1'b1};
      vecs[10] = '{8,    1'b0,   1, 1'b0};
      vecs[11] = '{7,    1'b0,   0, 1'b0};
      vecs[12] = '{1,    1'b0,   0, 1'b0};

      rst_n            = 1'b0;
      bus.i_VSync      = 1'b1;
      bus.i_555_Output = 1'b0;
      repeat (3) @(negedge clk);
      check("reset trigger", int'(bus.o_555_Trigger), 1);
      check("reset position", int'(bus.o_Position), 0);
      check("reset valid", int'(bus.o_Valid), 0);
      check("reset timeout", int'(bus.o_Timeout), 0);
      check("reset state", int'(bus.o_State), ST_IDLE);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      foreach (vecs[i]) begin
         run_frame(vecs[i].pulse, vecs[i].extra_vsync, vecs[i].exp_timeout, vecs[i].exp_new,
                   $sformatf("vec%0d", i));
      end

      // Frame-start edge landing in the DONE cycle must not start a new frame.
      v0 = valid_total;
      start_frame(lows);
      check("done_edge trig_len", lows, TRIG_CYCLES);
      drive_pulse(400, 1'b0);
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (int'(bus.o_State) == ST_DONE) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("done_edge reached_done", int'(found), 1);
      bus.i_VSync = 1'b0;
      @(negedge clk);
      bus.i_VSync = 1'b1;
      lows = 0;
      for (int i = 0; i < 40; i++) begin
         if (bus.o_555_Trigger == 1'b0) lows++;
         @(negedge clk);
      end
      check("done_edge no_retrigger", lows, 0);
      model_update(1'b0, 50);
      check_result("done_edge", v0);

      // Reset in the middle of the trigger pulse.
      @(negedge clk);
      bus.i_VSync = 1'b0;
      @(negedge clk);
      bus.i_VSync = 1'b1;
      repeat (8) @(negedge clk);
      check("mid_reset trig_before", int'(bus.o_555_Trigger), 0);
      #2 rst_n = 1'b0;
      #1;
      check("mid_reset trigger", int'(bus.o_555_Trigger), 1);
      check("mid_reset position", int'(bus.o_Position), 0);
      check("mid_reset timeout", int'(bus.o_Timeout), 0);
      check("mid_reset state", int'(bus.o_State), ST_IDLE);
      @(negedge clk);
      rst_n   = 1'b1;
      exp_pos = 0;
      exp_to  = 1'b0;
      repeat (3) @(negedge clk);

      // Random pulse widths against the model.
      for (int i = 0; i < 8; i++) begin
         n = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, MAX_COUNT + 300));
         run_frame(n, 1'($urandom_range(0, 1)), model_timeout(n), model_new(n),
                   $sformatf("rand%0d n=%0d", i, n));
      end

      check("valid_during_trigger", valid_in_trig, 0);
      check("scoreboard_drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
